fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Holds the PC register and computes the next PC: sequential PC+4, or the redirect target from execute.
- Drives the instruction-memory address and captures the returned word in the IF/ID pipeline register.
- Produces InstrD, PCD, PCPlus4D and ValidD for decode. Honours stall and flush from the hazard unit and keeps a fetch counter.

Parameters:
- DATA_WIDTH, 32, datapath and PC width.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- StallF  input  1  hold PC (hazard unit).
- StallD  input  1  hold IF/ID register (hazard unit).
- FlushD  input  1  replace IF/ID contents with bubble.
- PCSrcE  input  1  redirect request from execute (taken branch/jump).
- PCTargetE  input  DATA_WIDTH  redirect target from execute.
- InstrF  input  DATA_WIDTH  word returned combinationally by instruction memory for PCF.
- PCF  output  DATA_WIDTH  current fetch address to instruction memory.
- InstrD  output  DATA_WIDTH  registered instruction to decode.
- PCD  output  DATA_WIDTH  registered PC of InstrD.
- PCPlus4D  output  DATA_WIDTH  registered PCD+4.
- ValidD  output  1  InstrD is a real fetched instruction (0 = bubble).
- FetchCount  output  DATA_WIDTH  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset, asynchronous, effective immediately on rst=1:
  - PCF=RESET_PC
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0
  - FetchCount=0
  - Deassertion takes effect at the next rising edge. The first fetch is RESET_PC.
- PCPlus4F = PCF + 4, modulo 2^DATA_WIDTH. 32'hFFFFFFFC wraps to 0 with no flag.
- Redirect target = {PCTargetE[31:2], 2'b00}. Low bits are always cleared, so the PC stays word-aligned.
- PC register update at each rising edge, first matching rule wins:
  1. PCSrcE=1: PCF <= aligned PCTargetE. The redirect overrides StallF.
  2. StallF=1: PCF unchanged.
  3. Otherwise: PCF <= PCPlus4F.
- IF/ID register update at each rising edge, first matching rule wins:
  1. FlushD=1 or PCSrcE=1: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0. The flush overrides StallD.
  2. StallD=1: all IF/ID outputs unchanged.
  3. Otherwise: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Latency: one cycle from PCF presentation to InstrD. A redirect costs two bubbles: the wrong-path word in IF/ID is flushed this edge, and decode is flushed externally by the hazard unit.
- FetchCount increments by 1 only on IF/ID rule 3. It wraps at 2^DATA_WIDTH to 0.
- StallF=1 with StallD=0 is legal: IF/ID reloads the same PCF word, ValidD=1, and the count increments.
- Reset asserted mid-stall or mid-redirect discards all pending state with no partial update.
- Control signals are sampled only at clock edges. There are no combinational paths from inputs to registered outputs. PCF is a pure register output.

Decomposition:
- pipeline_pkg holds DATA_WIDTH, RESET_PC, NOP_INSTR and a pc_t typedef (logic [DATA_WIDTH-1:0]). The decode and execute stages share this package.
- One sub-module, if_id_reg: IF/ID register with enable (~StallD), synchronous clear (FlushD|PCSrcE) and asynchronous reset.
- PC register, next-PC mux, adder and FetchCount stay in fetch_stage.

Test Plan:
1. Reset then release, with imem returning 32'h00500093 at 0 and 32'h00100113 at 4 → PCF 0,4,8. Cycle after first edge: InstrD=32'h00500093, PCD=0, PCPlus4D=4, ValidD=1. Next: InstrD=32'h00100113. FetchCount=2.
2. StallF=StallD=1 for 3 cycles at PCF=8 → PCF stays 8, IF/ID unchanged, FetchCount frozen. Release → PCF=12 next edge.
3. PCSrcE=1, PCTargetE=32'h00000102 at PCF=16 → next PCF=32'h00000100, InstrD=NOP_INSTR, ValidD=0, FetchCount unchanged. Following edge: InstrD=mem[0x100], PCD=32'h100.
4. FlushD=1 and StallD=1 together → bubble inserted (InstrD=32'h00000013, ValidD=0). StallF=1 with PCSrcE=1 → PCF takes target.
5. PC at 32'hFFFFFFFC, no stall → next PCF=0, PCPlus4D of captured word = 0.
6. rst asserted asynchronously mid-cycle with PCF=32'h40 and ValidD=1 → outputs return to reset values before the next edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline stages.
// Holds the datapath width, the reset PC, the bubble instruction and the
// PC type used by fetch, decode and execute.
package pipeline_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

  typedef logic [DATA_WIDTH-1:0] pc_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_en                load enable (low = hold)
//   i_clr               synchronous clear to a bubble, wins over i_en
//   i_instr/i_pc/i_pc4  fetched word, its PC and PC+4
//   o_instr/o_pc/o_pc4  registered copies for decode
//   o_valid             1 = real instruction, 0 = bubble
module if_id_reg #(
  parameter int                    DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_pc4,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc4,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pc4;
  logic                  r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   StallF/StallD   hold PC / hold IF/ID (hazard unit)
//   FlushD          replace IF/ID with a bubble
//   PCSrcE          redirect from execute to PCTargetE (word-aligned)
//   InstrF          combinational imem word for PCF
//   PCF             registered fetch address
//   InstrD/PCD/PCPlus4D/ValidD  IF/ID contents for decode
//   FetchCount      instructions accepted into IF/ID since reset
module fetch_stage #(
  parameter int                    DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = pipeline_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [DATA_WIDTH-1:0] FetchCount
);

  logic [DATA_WIDTH-1:0] r_pcf;
  logic [DATA_WIDTH-1:0] r_fetch_count;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_clr_d;
  logic                  w_load_d;

  assign w_pc_plus4 = r_pcf + DATA_WIDTH'(4);
  // Masking keeps every target bit in use and forces word alignment.
  assign w_target   = PCTargetE & ~DATA_WIDTH'(3);

  // A redirect wins over a stall: the wrong-path fetch must be abandoned.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (PCSrcE)      w_pc_next = w_target;
    else if (StallF) w_pc_next = r_pcf;
  end

  // The word in IF/ID is wrong-path whenever execute redirects.
  assign w_clr_d  = FlushD | PCSrcE;
  assign w_load_d = ~w_clr_d & ~StallD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcf         <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pcf <= w_pc_next;
      if (w_load_d) r_fetch_count <= r_fetch_count + DATA_WIDTH'(1);
    end
  end

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_en    (~StallD),
    .i_clr   (w_clr_d),
    .i_instr (InstrF),
    .i_pc    (r_pcf),
    .i_pc4   (w_pc_plus4),
    .o_instr (InstrD),
    .o_pc    (PCD),
    .o_pc4   (PCPlus4D),
    .o_valid (ValidD)
  );

  assign PCF        = r_pcf;
  assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD;

  int tests = 0;
  int fails = 0;

  // Reference state: what the stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory: two fixed words, hashed contents elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign InstrF = imem(PCF);

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchCount (FetchCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PCF"}, PCF, m_pc);
    check({tag, ".InstrD"}, InstrD, m_instr);
    check({tag, ".PCD"}, PCD, m_pcd);
    check({tag, ".PCPlus4D"}, PCPlus4D, m_pc4d);
    check({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, m_valid});
    check({tag, ".FetchCount"}, FetchCount, m_cnt);
    $display("[TB] %s pc=%h instrD=%h pcD=%h validD=%0d cnt=%0d", tag, PCF, InstrD, PCD, ValidD, FetchCount);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic set_ctl(input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
  endtask

  // One clock: predict from the architectural rules, clock, then compare.
  task automatic cycle(input string tag);
    logic [31:0] npc;
    npc = PCSrcE ? (PCTargetE & 32'hFFFF_FFFC) : (StallF ? m_pc : m_pc + 32'd4);
    if (FlushD || PCSrcE) begin
      m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
    end else if (!StallD) begin
      m_instr = imem(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1;
      m_cnt = m_cnt + 1;
    end
    m_pc = npc;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and check it acts before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_ctl(0, 0, 0, 0, 32'h0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: sequential fetch
    cycle("seq0");
    check("seq0.InstrD_lit", InstrD, 32'h0050_0093);
    check("seq0.PCPlus4D_lit", PCPlus4D, 32'h4);
    cycle("seq1");
    check("seq1.InstrD_lit", InstrD, 32'h0010_0113);
    check("seq1.FetchCount_lit", FetchCount, 32'd2);
    check("seq1.PCF_lit", PCF, 32'h8);

    // 2: full stall
    set_ctl(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("stall");
    check("stall.PCF_lit", PCF, 32'h8);
    set_ctl(0, 0, 0, 0, 0);
    cycle("unstall");
    check("unstall.PCF_lit", PCF, 32'hC);
    cycle("seq2");

    // 3: redirect with misaligned target
    set_ctl(0, 0, 0, 1, 32'h0000_0102);
    cycle("redir");
    check("redir.PCF_lit", PCF, 32'h100);
    check("redir.InstrD_lit", InstrD, NOP);
    set_ctl(0, 0, 0, 0, 0);
    cycle("redir_next");
    check("redir_next.PCD_lit", PCD, 32'h100);

    // 4: flush beats stall; redirect beats PC stall
    set_ctl(0, 1, 1, 0, 0);
    cycle("flush_stall");
    check("flush_stall.ValidD_lit", {31'd0, ValidD}, 32'd0);
    set_ctl(1, 0, 0, 1, 32'h0000_0203);
    cycle("stallF_redir");
    check("stallF_redir.PCF_lit", PCF, 32'h200);
    set_ctl(1, 0, 0, 0, 0);
    cycle("stallF_only");

    // 5: PC wrap
    set_ctl(0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle("to_top");
    set_ctl(0, 0, 0, 0, 0);
    cycle("wrap");
    check("wrap.PCF_lit", PCF, 32'h0);
    check("wrap.PCPlus4D_lit", PCPlus4D, 32'h0);

    // 6: async reset with a valid word at 0x40
    set_ctl(0, 0, 0, 1, 32'h0000_003C);
    cycle("to_3c");
    set_ctl(0, 0, 0, 0, 0);
    cycle("at_40");
    check("at_40.PCF_lit", PCF, 32'h40);
    async_reset("async_rst");
    cycle("restart");
    check("restart.PCD_lit", PCD, 32'h0);

    // Randomised traffic, including occasional reset and near-wrap targets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      set_ctl($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, tgt);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
